// File: rtl/dr_scan_host_pkg.sv
// Shared constants for the DR scan host: FSM state encodings and counter sizing.
package dr_scan_host_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StCapture = 3'd1;
  localparam state_t StShift   = 3'd2;
  localparam state_t StUpdate  = 3'd3;
  localparam state_t StDone    = 3'd4;

  // Bit counter must stay at least one bit wide even for a 1-bit register.
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/dr_scan_host_if.sv
// Link between the scan FSM (master) and the shift-register datapath (slave).
interface dr_scan_host_if #(
  parameter int unsigned LEN = 32
);

  logic           load;
  logic           shift_en;
  logic [LEN-1:0] load_data;
  logic           last;
  logic           tdi_bit;
  logic [LEN-1:0] rx_data;

  modport master (
    output load, shift_en, load_data,
    input  last, tdi_bit, rx_data
  );

  modport slave (
    input  load, shift_en, load_data,
    output last, tdi_bit, rx_data
  );

endinterface

// File: rtl/dr_scan_shifter.sv
// Scan datapath: outgoing pattern register, incoming capture register and bit counter.
module dr_scan_shifter
  import dr_scan_host_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic            clkDR,
  input  logic            reset,
  input  logic            tdo,
  dr_scan_host_if.slave   lnk
);

  localparam int unsigned      CntW    = cnt_width(LEN);
  localparam logic [CntW-1:0]  CntLast = CntW'(LEN - 1);

  logic [LEN-1:0]  tx_q, tx_d;
  logic [LEN-1:0]  rx_q, rx_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    cnt_d = cnt_q;
    if (lnk.load) begin
      tx_d  = lnk.load_data;
      cnt_d = '0;
    end else if (lnk.shift_en) begin
      tx_d  = tx_q >> 1;
      // Each new tdo bit enters at the MSB so the first sample ends up in bit 0.
      rx_d  = (rx_q >> 1) | (LEN'(tdo) << (LEN - 1));
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clkDR or posedge reset) begin
    if (reset) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
    end
  end

  assign lnk.last    = (cnt_q == CntLast);
  assign lnk.tdi_bit = tx_q[0];
  assign lnk.rx_data = rx_q;

endmodule

// File: rtl/dr_scan_host.sv
// DR scan host: runs one capture/shift/update sequence per accepted start and
// compares the captured data against a masked expected value.
module dr_scan_host
  import dr_scan_host_pkg::*;
#(
  parameter int unsigned LEN = 32
) (
  input  logic           clkDR,
  input  logic           reset,
  input  logic           start,
  input  logic [LEN-1:0] pattern,
  input  logic [LEN-1:0] expected,
  input  logic [LEN-1:0] mask,
  input  logic           tdo,
  output logic           tdi,
  output logic           captureDR,
  output logic           shiftDR,
  output logic           updateDR,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] result,
  output logic           mismatch
);

  dr_scan_host_if #(.LEN(LEN)) lnk ();

  state_t         state_q, state_d;
  logic [LEN-1:0] exp_q, exp_d;
  logic [LEN-1:0] mask_q, mask_d;
  logic           mismatch_q, mismatch_d;
  logic           load;
  logic           shift_en;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    mismatch_d = mismatch_q;
    load       = 1'b0;
    shift_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCapture;
          load       = 1'b1;
          exp_d      = expected;
          mask_d     = mask;
          mismatch_d = 1'b0;
        end
      end
      StCapture: state_d = StShift;
      StShift: begin
        shift_en = 1'b1;
        if (lnk.last) state_d = StUpdate;
      end
      StUpdate: begin
        // Capture register is complete here; latch the verdict as DONE is entered.
        state_d    = StDone;
        mismatch_d = |((lnk.rx_data ^ exp_q) & mask_q);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkDR or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      exp_q      <= '0;
      mask_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign lnk.load      = load;
  assign lnk.shift_en  = shift_en;
  assign lnk.load_data = pattern;

  dr_scan_shifter #(
    .LEN (LEN)
  ) u_shifter (
    .clkDR (clkDR),
    .reset (reset),
    .tdo   (tdo),
    .lnk   (lnk)
  );

  // Outputs decode straight from reset flops so reset clears them without a clock.
  assign captureDR = (state_q == StCapture);
  assign shiftDR   = (state_q == StShift);
  assign updateDR  = (state_q == StUpdate);
  assign done      = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign tdi       = shiftDR & lnk.tdi_bit;
  assign result    = lnk.rx_data;
  assign mismatch  = mismatch_q;

endmodule
